// File: rtl/pad_lbk_pkg.sv
// Shared types and constants for the pad loopback self-test engine.
// Optional feature macro: PAD_LBK_WALK_EN (adds the walking-one drive steps).
package pad_lbk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Fixed drive steps come first, then optional walking ones, then PU and PD.
    localparam int STEP_ZERO  = 0;
    localparam int STEP_ONE   = 1;
    localparam int STEP_ODD   = 2;
    localparam int STEP_EVEN  = 3;
    localparam int STEP_WALK0 = 4;

`ifdef PAD_LBK_WALK_EN
    localparam bit WALK_EN = 1'b1;
`else
    localparam bit WALK_EN = 1'b0;
`endif

    // Total number of steps in one run, including the PU and PD steps.
    function automatic int n_steps(input int nb);
        return STEP_WALK0 + (WALK_EN ? nb : 0) + 2;
    endfunction

endpackage

// File: rtl/pad_lbk_pattern.sv
// Step-index to pad-control pattern decoder (purely combinational).
// Optional feature macro: PAD_LBK_WALK_EN (decodes the walking-one steps).
module pad_lbk_pattern
    import pad_lbk_pkg::*;
#(
    parameter int NUM_BIDIR = 42,
    parameter int STEP_W    = 3
) (
    input  logic [STEP_W-1:0]    i_step,
    output logic [NUM_BIDIR-1:0] o_out,
    output logic [NUM_BIDIR-1:0] o_oe,
    output logic [NUM_BIDIR-1:0] o_pu,
    output logic [NUM_BIDIR-1:0] o_pd,
    output logic [NUM_BIDIR-1:0] o_exp
);

    localparam int N_STEPS = n_steps(NUM_BIDIR);
    localparam logic [STEP_W-1:0] PU_STEP = STEP_W'(N_STEPS - 2);
    localparam logic [STEP_W-1:0] PD_STEP = STEP_W'(N_STEPS - 1);
`ifdef PAD_LBK_WALK_EN
    localparam logic [NUM_BIDIR-1:0] ONE_HOT0 = NUM_BIDIR'(1);
`endif

    logic [NUM_BIDIR-1:0] w_odd;

    // Decode the current step into drive/pull controls and the expected readback.
    always_comb begin
        o_out = '0;
        o_oe  = '0;
        o_pu  = '0;
        o_pd  = '0;
        o_exp = '0;
        for (int i = 0; i < NUM_BIDIR; i++) w_odd[i] = (i % 2) == 1;
        if (i_step == PU_STEP) begin
            o_pu  = '1;
            o_exp = '1;
        end else if (i_step == PD_STEP) begin
            o_pd  = '1;
            o_exp = '0;
        end else if (int'(i_step) < STEP_WALK0) begin
            o_oe = '1;
            case (int'(i_step))
                STEP_ZERO: o_out = '0;
                STEP_ONE:  o_out = '1;
                STEP_ODD:  o_out = w_odd;
                STEP_EVEN: o_out = ~w_odd;
                default:   o_out = '0;
            endcase
            o_exp = o_out;
        end
`ifdef PAD_LBK_WALK_EN
        else begin
            // Walking one: a single driven-high pad exposes shorts to any neighbour.
            o_oe  = '1;
            o_out = ONE_HOT0 << (i_step - STEP_W'(STEP_WALK0));
            o_exp = o_out;
        end
`endif
    end

endmodule

// File: rtl/pad_loopback_tester.sv
// Pad loopback self-test: drives pad patterns, reads them back, accumulates
// a sticky per-pad fail mask. Optional feature macro: PAD_LBK_WALK_EN.
module pad_loopback_tester
    import pad_lbk_pkg::*;
#(
    parameter int NUM_BIDIR     = 42,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [NUM_BIDIR-1:0] io_in,
    output logic [NUM_BIDIR-1:0] io_out,
    output logic [NUM_BIDIR-1:0] io_oe,
    output logic [NUM_BIDIR-1:0] io_pu,
    output logic [NUM_BIDIR-1:0] io_pd,
    output logic [NUM_BIDIR-1:0] io_ie,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 pass_o,
    output logic [NUM_BIDIR-1:0] fail_mask_o
);

    localparam int N_STEPS = n_steps(NUM_BIDIR);
    localparam int STEP_W  = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
    localparam int SET_W   = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP   = STEP_W'(N_STEPS - 1);
    localparam logic [SET_W-1:0]  LAST_SETTLE = SET_W'(SETTLE_CYCLES);

    state_t               r_state;
    state_t               w_next;
    logic [STEP_W-1:0]    r_step;
    logic [SET_W-1:0]     r_settle;
    logic [NUM_BIDIR-1:0] r_fail;

    logic [NUM_BIDIR-1:0] w_pat_out;
    logic [NUM_BIDIR-1:0] w_pat_oe;
    logic [NUM_BIDIR-1:0] w_pat_pu;
    logic [NUM_BIDIR-1:0] w_pat_pd;
    logic [NUM_BIDIR-1:0] w_pat_exp;
    logic                 w_sample;
    logic                 w_last;
    logic                 w_accept;

    pad_lbk_pattern #(
        .NUM_BIDIR (NUM_BIDIR),
        .STEP_W    (STEP_W)
    ) u_pattern (
        .i_step (r_step),
        .o_out  (w_pat_out),
        .o_oe   (w_pat_oe),
        .o_pu   (w_pat_pu),
        .o_pd   (w_pat_pd),
        .o_exp  (w_pat_exp)
    );

    // Sample on the final settle cycle of each step; start only counts when idle/done.
    assign w_sample = (r_state == RUN) && (r_settle == LAST_SETTLE);
    assign w_last   = (r_step == LAST_STEP);
    assign w_accept = (r_state != RUN) && start_i;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic: start launches a run, the last PD sample finishes it.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: if (start_i) w_next = RUN;
            RUN:        if (w_sample && w_last) w_next = DONE;
            default:    w_next = IDLE;
        endcase
    end

    // Step/settle counters and sticky fail mask; cleared on every accepted start.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_step   <= '0;
            r_settle <= '0;
            r_fail   <= '0;
        end else if (w_accept) begin
            r_step   <= '0;
            r_settle <= '0;
            r_fail   <= '0;
        end else if (r_state == RUN) begin
            if (w_sample) begin
                r_fail   <= r_fail | (io_in ^ w_pat_exp);
                r_settle <= '0;
                // Hold at the last step so the counter never wraps.
                if (!w_last) r_step <= r_step + STEP_W'(1);
            end else begin
                r_settle <= r_settle + SET_W'(1);
            end
        end
    end

    // Outputs: pattern only while running; pads released and inputs enabled otherwise.
    always_comb begin
        io_out = '0;
        io_oe  = '0;
        io_pu  = '0;
        io_pd  = '0;
        io_ie  = '1;
        if (r_state == RUN) begin
            io_out = w_pat_out;
            io_oe  = w_pat_oe;
            io_pu  = w_pat_pu;
            io_pd  = w_pat_pd;
        end
    end

    assign busy_o      = (r_state == RUN);
    assign done_o      = (r_state == DONE);
    assign pass_o      = (r_state == DONE) && (r_fail == '0);
    assign fail_mask_o = r_fail;

endmodule

// File: tb/tb_pad_loopback_tester.sv
// Directed bench for pad_loopback_tester (NUM_BIDIR=8, SETTLE_CYCLES=2) with
// a behavioural pad model and injectable faults.
module tb_pad_loopback_tester;

    localparam int NB = 8;
`ifdef PAD_LBK_WALK_EN
    localparam int NSTEP = 14;
`else
    localparam int NSTEP = 6;
`endif
    localparam int DONE_AT = 1 + NSTEP * 3;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic [NB-1:0] io_in, io_out, io_oe, io_pu, io_pd, io_ie, fail_mask_o;
    logic          busy_o, done_o, pass_o;
    logic [NB-1:0] w_pad;
    int            fmode;  // 0 ideal, 1 pad3 stuck-0, 2 pads 2/5 wired-AND, 3 pad5 PU broken

    int n_checks = 0;
    int n_pass   = 0;

    pad_loopback_tester #(.NUM_BIDIR(NB), .SETTLE_CYCLES(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .io_in(io_in),
        .io_out(io_out), .io_oe(io_oe), .io_pu(io_pu), .io_pd(io_pd), .io_ie(io_ie),
        .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .fail_mask_o(fail_mask_o)
    );

    always #5 clk_i = ~clk_i;

    // Pad model: driven value, else pull-up, else pull-down/float reads 0.
    always_comb begin
        for (int i = 0; i < NB; i++) w_pad[i] = io_oe[i] ? io_out[i] : (io_pu[i] ? 1'b1 : 1'b0);
        io_in = w_pad;
        if (fmode == 1) io_in[3] = 1'b0;
        if (fmode == 2) begin
            io_in[2] = w_pad[2] & w_pad[5];
            io_in[5] = w_pad[2] & w_pad[5];
        end
        if (fmode == 3 && !io_oe[5] && io_pu[5]) io_in[5] = 1'b0;
    end

    typedef struct {
        int            fm;
        logic [NB-1:0] mask;
        logic          pass;
    } vec_t;
    vec_t tbl[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        start_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    // Pulse start during cycle T; returns positioned at T+1.
    task automatic do_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    // Wait for done_o; c is the cycle offset from T (entered at T+1).
    task automatic wait_done(output int c);
        c = 1;
        while (!done_o && c < 200) begin
            tick();
            c++;
        end
    endtask

    initial begin
        int c;
        rst_i = 1'b1;
        start_i = 1'b0;
        fmode = 0;
        tbl[0] = '{fm: 0, mask: 8'h00, pass: 1'b1};
        tbl[1] = '{fm: 1, mask: 8'h08, pass: 1'b0};
        tbl[2] = '{fm: 2, mask: 8'h24, pass: 1'b0};
        tbl[3] = '{fm: 3, mask: 8'h20, pass: 1'b0};

        // Reset values
        do_reset();
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_pass", pass_o, 1'b0);
        chk("rst_mask", fail_mask_o, 8'h00);
        chk("rst_oe", io_oe, 8'h00);
        chk("rst_pu_pd_out", {io_pu, io_pd, io_out}, 24'h0);
        chk("rst_ie", io_ie, 8'hFF);

        // Ideal-pad run: step pattern spot checks along the way
        fmode = 0;
        do_start();
        chk("t1_busy", busy_o, 1'b1);
        chk("t1_oe", io_oe, 8'hFF);
        chk("t1_out", io_out, 8'h00);
        tick(); tick(); tick();                 // T+4: step 1
        chk("t4_out", io_out, 8'hFF);
        tick(); tick(); tick();                 // T+7: step 2
        chk("t7_out_odd", io_out, 8'hAA);
        tick(); tick(); tick();                 // T+10: step 3
        chk("t10_out_even", io_out, 8'h55);
        for (int k = 0; k < 3 * (NSTEP - 6); k++) tick();
        tick(); tick(); tick();                 // PU step
        chk("pu_ctrl", {io_oe, io_pu, io_pd}, {8'h00, 8'hFF, 8'h00});
        tick(); tick(); tick();                 // PD step
        chk("pd_ctrl", {io_oe, io_pu, io_pd}, {8'h00, 8'h00, 8'hFF});
        chk("pd_busy", busy_o, 1'b1);
        tick(); tick(); tick();                 // done
        chk("ideal_done", done_o, 1'b1);
        chk("ideal_done_ctrl", {io_oe, io_pu, io_pd, io_out, io_ie}, {32'h0, 8'hFF});

        // Fault table
        for (int v = 0; v < 4; v++) begin
            do_reset();
            fmode = tbl[v].fm;
            do_start();
            chk($sformatf("v%0d_busy", v), busy_o, 1'b1);
            wait_done(c);
            chk($sformatf("v%0d_done_cycle", v), c, DONE_AT);
            chk($sformatf("v%0d_mask", v), fail_mask_o, tbl[v].mask);
            chk($sformatf("v%0d_pass", v), pass_o, tbl[v].pass);
            chk($sformatf("v%0d_busy_low", v), busy_o, 1'b0);
        end

        // Stuck pad: flag timing, and a start during the run is ignored
        do_reset();
        fmode = 1;
        do_start();                             // T+1
        tick(); tick(); tick();                 // T+4
        start_i = 1'b1;
        tick();                                 // T+5, start sampled here
        start_i = 1'b0;
        tick();                                 // T+6
        chk("stk_t6_mask", fail_mask_o, 8'h00);
        tick();                                 // T+7
        chk("stk_t7_mask", fail_mask_o, 8'h08);
        c = 7;
        while (!done_o && c < 200) begin
            tick();
            c++;
        end
        chk("stk_done_cycle", c, DONE_AT);

        // Restart from DONE clears the mask
        fmode = 0;
        do_start();
        chk("rs_mask", fail_mask_o, 8'h00);
        chk("rs_done", done_o, 1'b0);
        chk("rs_busy", busy_o, 1'b1);
        wait_done(c);
        chk("rs_pass", pass_o, 1'b1);

        // Reset mid-run wins over everything
        do_reset();
        fmode = 1;
        do_start();                             // T+1
        for (int k = 0; k < 9; k++) tick();     // T+10
        chk("mr_mask_before", fail_mask_o, 8'h08);
        rst_i = 1'b1;
        start_i = 1'b1;
        tick();                                 // T+11
        rst_i = 1'b0;
        start_i = 1'b0;
        chk("mr_busy", busy_o, 1'b0);
        chk("mr_mask", fail_mask_o, 8'h00);
        chk("mr_outs", {io_oe, io_pu, io_pd, io_out, io_ie}, {32'h0, 8'hFF});
        chk("mr_done_pass", {done_o, pass_o}, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
